// File: rtl/reg_dump_pkg.sv
// Shared types for the register-file dump reader.
package reg_dump_pkg;

  // Default geometry of the register file being dumped.
  localparam int DUMP_W = 8;
  localparam int DUMP_A = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage : reg_dump_pkg

// File: rtl/reg_dump_reader_if.sv
// Register read port plus valid/ready dump stream of the dump reader.
// The master side is the dump reader; the slave side is the register
// file read port together with the stream consumer.
interface reg_dump_reader_if #(
  parameter int W = 8,
  parameter int A = 3
) ();

  logic [A-1:0] RegAddr;
  logic [W-1:0] RegData;
  logic         DumpValid;
  logic         DumpReady;
  logic [A-1:0] DumpAddr;
  logic [W-1:0] DumpData;
  logic         DumpLast;

  modport master (
    output RegAddr,
    input  RegData,
    output DumpValid,
    input  DumpReady,
    output DumpAddr,
    output DumpData,
    output DumpLast
  );

  modport slave (
    input  RegAddr,
    output RegData,
    input  DumpValid,
    output DumpReady,
    input  DumpAddr,
    input  DumpData,
    input  DumpLast
  );

endinterface : reg_dump_reader_if

// File: rtl/reg_dump_reader.sv
// Sequential debug reader: walks register addresses 0..2**A-1 over a spare
// combinational read port and streams (address, data) beats out on a
// valid/ready interface. Holds HaltReq while active so the core can stall
// register writes. It never writes the register file.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int W = DUMP_W,
  parameter int A = DUMP_A
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Abort,
  reg_dump_reader_if.master  bus,
  output logic               Busy,
  output logic               HaltReq,
  output logic               Done
);

  // Index of the final register; terminal test happens before increment so
  // the index never wraps within a dump.
  localparam logic [A-1:0] LAST_IDX = {A{1'b1}};

  dump_state_t  r_state;
  logic [A-1:0] r_index;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_data;
  logic         r_last;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;

  // Dump FSM with index counter, snapshot hold register and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_index <= {A{1'b0}};
      r_addr  <= {A{1'b0}};
      r_data  <= {W{1'b0}};
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (Abort && (r_state != IDLE)) begin
      // Cancel: a beat handshaken in this same cycle still counts as
      // delivered, but the dump ends without a Done pulse.
      r_state <= IDLE;
      r_index <= {A{1'b0}};
      r_addr  <= {A{1'b0}};
      r_data  <= {W{1'b0}};
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Start together with Abort keeps the reader idle.
          if (Start && !Abort) begin
            r_state <= READ;
            r_index <= {A{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        READ: begin
          // Snapshot the register so later writes cannot alter this beat.
          r_data  <= bus.RegData;
          r_addr  <= r_index;
          r_last  <= (r_index == LAST_IDX);
          r_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (bus.DumpReady) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_index == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_index <= r_index + {{(A-1){1'b0}}, 1'b1};
              r_state <= READ;
            end
          end else begin
            // Backpressure: hold state and every Dump* output.
            r_state <= SEND;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_index <= {A{1'b0}};
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_index <= {A{1'b0}};
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RegAddr   = r_index;
  assign bus.DumpValid = r_valid;
  assign bus.DumpAddr  = r_addr;
  assign bus.DumpData  = r_data;
  assign bus.DumpLast  = r_last;
  assign Busy          = r_busy;
  assign HaltReq       = r_busy;
  assign Done          = r_done;

endmodule : reg_dump_reader
